// File: rtl/spi_slave.sv
// SPI slave front-end for a single-port RAM.
// Receives 10-bit frames (2-bit command + 8-bit address/data) on MOSI and
// forwards each completed frame as a one-cycle rx_valid strobe. In the
// read-data phase it captures one byte from the RAM and shifts it out on
// MISO, MSB first. clk doubles as the SPI bit clock.
module spi_slave (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SS_n,
    input  logic       MOSI,
    output logic       MISO,
    output logic [9:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CHK_CMD   = 3'd1;
    localparam logic [2:0] WRITE     = 3'd2;
    localparam logic [2:0] READ_ADD  = 3'd3;
    localparam logic [2:0] READ_DATA = 3'd4;

    // Counter value once all ten frame bits have been taken in.
    localparam logic [3:0] FRAME_BITS = 4'd10;
    localparam logic [3:0] LAST_BIT   = 4'd9;

    logic [2:0] state_reg;
    logic [2:0] state_next;
    logic [3:0] bit_cnt_reg;
    logic [8:0] rx_shift_reg;      // frame bits 9..1 collected so far
    logic       rd_addr_flag_reg;  // a read address has been sent, next read is data
    logic [7:0] tx_shift_reg;
    logic [2:0] tx_cnt_reg;        // MISO bits still to present after the current one
    logic       tx_loaded_reg;     // read byte already captured in this frame

    logic in_frame_state;
    logic frame_done;
    logic frame_last;
    logic tx_load;

    assign in_frame_state = (state_reg == WRITE) || (state_reg == READ_ADD) ||
                            (state_reg == READ_DATA);
    assign frame_done     = (bit_cnt_reg == FRAME_BITS);
    // Bit 0 is on MOSI this cycle; a simultaneous SS_n rise aborts the frame.
    assign frame_last     = in_frame_state && (bit_cnt_reg == LAST_BIT) && !SS_n;
    // Only the first tx_valid after the read-data frame has completed is taken.
    assign tx_load        = (state_reg == READ_DATA) && frame_done && !tx_loaded_reg &&
                            tx_valid && !SS_n;

    // Next-state logic: SS_n high always returns to IDLE, command bit picks the branch.
    always_comb begin
        state_next = state_reg;
        if (state_reg != IDLE && SS_n) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!SS_n) begin
                        state_next = CHK_CMD;
                    end
                end
                CHK_CMD: begin
                    if (!MOSI) begin
                        state_next = WRITE;
                    end else if (rd_addr_flag_reg) begin
                        state_next = READ_DATA;
                    end else begin
                        state_next = READ_ADD;
                    end
                end
                WRITE, READ_ADD, READ_DATA: begin
                    state_next = state_reg;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Shift in frame bits and count them; bits after a complete frame are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_reg  <= '0;
            rx_shift_reg <= '0;
        end else if (SS_n || state_reg == IDLE) begin
            bit_cnt_reg <= '0;
        end else if (state_reg == CHK_CMD) begin
            rx_shift_reg <= {rx_shift_reg[7:0], MOSI};
            bit_cnt_reg  <= 4'd1;
        end else if (!frame_done) begin
            rx_shift_reg <= {rx_shift_reg[7:0], MOSI};
            bit_cnt_reg  <= bit_cnt_reg + 4'd1;
        end
    end

    // Publish the completed frame with a single-cycle strobe; rx_data holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= frame_last;
            if (frame_last) begin
                rx_data <= {rx_shift_reg, MOSI};
            end
        end
    end

    // Track whether the next read frame carries data rather than an address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_flag_reg <= 1'b0;
        end else if (frame_last) begin
            if (state_reg == READ_ADD) begin
                rd_addr_flag_reg <= 1'b1;
            end else if (state_reg == READ_DATA) begin
                rd_addr_flag_reg <= 1'b0;
            end
        end
    end

    // Capture the read byte once and shift it out MSB first; MISO idles low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift_reg  <= '0;
            tx_cnt_reg    <= '0;
            tx_loaded_reg <= 1'b0;
            MISO          <= 1'b0;
        end else if (state_reg != READ_DATA || SS_n) begin
            tx_shift_reg  <= '0;
            tx_cnt_reg    <= '0;
            tx_loaded_reg <= 1'b0;
            MISO          <= 1'b0;
        end else if (tx_load) begin
            MISO          <= tx_data[7];
            tx_shift_reg  <= {tx_data[6:0], 1'b0};
            tx_cnt_reg    <= 3'd7;
            tx_loaded_reg <= 1'b1;
        end else if (tx_cnt_reg != 3'd0) begin
            MISO         <= tx_shift_reg[7];
            tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
            tx_cnt_reg   <= tx_cnt_reg - 3'd1;
        end else begin
            MISO <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave. Stimulus tasks push expected frames and
// expected MISO bits into queues; a monitor on the falling edge pops and
// compares every cycle. The reference model only knows frames, the read
// address/data toggle and the byte to return.
module tb_spi_slave;

    logic       clk;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [9:0] exp_rx_q[$];
    logic       exp_miso_q[$];
    logic [9:0] last_rx = 10'h000;
    logic       flag_m = 1'b0;

    spi_slave dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: strict per-cycle comparison of the strobe, the frame and MISO.
    always @(negedge clk) begin
        logic       exp_valid;
        logic       exp_bit;
        logic [9:0] exp_frame;
        exp_valid = (exp_rx_q.size() != 0);
        chk("rx_valid", 32'(rx_valid), 32'(exp_valid));
        if (exp_valid) begin
            exp_frame = exp_rx_q.pop_front();
            chk("rx_data", 32'(rx_data), 32'(exp_frame));
            $display("rx frame got %03h expected %03h", rx_data, exp_frame);
            last_rx = exp_frame;
        end else begin
            chk("rx_hold", 32'(rx_data), 32'(last_rx));
        end
        exp_bit = (exp_miso_q.size() != 0) ? exp_miso_q.pop_front() : 1'b0;
        chk("miso", 32'(MISO), 32'(exp_bit));
    end

    // One SS_n-framed transaction. abort_after < 10: SS_n rises on the edge
    // that would sample that many-th bit (9 = same cycle as bit 0).
    task automatic send_frame(input logic [9:0] f, input int abort_after, input int extra,
                              input int tx_delay, input logic [7:0] txd);
        int kind;  // 0 write, 1 read address, 2 read data
        kind = !f[9] ? 0 : (flag_m ? 2 : 1);
        SS_n = 1'b0;
        MOSI = 1'($urandom);
        tick();
        for (int n = 0; n < 10; n++) begin
            MOSI = f[9-n];
            if (n == abort_after) begin
                SS_n = 1'b1;
                tick();
                tick();
                $display("frame %03h aborted after %0d bits", f, n);
                return;
            end
            tick();
            if (n == 9) exp_rx_q.push_back(f);
        end
        if (kind == 1) flag_m = 1'b1;
        else if (kind == 2) flag_m = 1'b0;
        if (kind == 2) begin
            repeat (tx_delay) begin
                MOSI = 1'($urandom);
                tick();
            end
            tx_data  = txd;
            tx_valid = 1'b1;
            tick();
            for (int b = 7; b >= 0; b--) exp_miso_q.push_back(txd[b]);
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
            tick();
            tx_data  = ~txd;
            tx_valid = 1'b1;
            tick();
            tx_valid = 1'b0;
            repeat (8) tick();
        end else begin
            tx_data  = txd;
            tx_valid = 1'b1;
            tick();
            tx_valid = 1'b0;
        end
        repeat (extra) begin
            MOSI     = 1'($urandom);
            tx_valid = 1'($urandom);
            tick();
        end
        tx_valid = 1'b0;
        SS_n     = 1'b1;
        tick();
        chk("rd_addr_flag", 32'(dut.rd_addr_flag_reg), 32'(flag_m));
        $display("frame %03h kind %0d done, flag %0b", f, kind, flag_m);
        tx_valid = 1'($urandom);
        tick();
        tx_valid = 1'b0;
    endtask

    initial begin
        logic [9:0] f;
        logic [7:0] rd_byte;
        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        repeat (2) tick();
        chk("reset_miso", 32'(MISO), 32'(0));
        chk("reset_rx_valid", 32'(rx_valid), 32'(0));
        chk("reset_rx_data", 32'(rx_data), 32'(10'h000));
        chk("reset_flag", 32'(dut.rd_addr_flag_reg), 32'(0));
        rst_n = 1'b1;
        tick();

        // Write address, write data with trailing bits, read address + read data, abort.
        send_frame(10'h0A5, 10, 0, 1, 8'h33);
        send_frame(10'h15A, 10, 3, 1, 8'h44);
        send_frame(10'h2A5, 10, 0, 1, 8'h00);
        send_frame(10'h300, 10, 1, 2, 8'h5A);
        send_frame(10'h1FF, 5, 0, 1, 8'h00);
        send_frame(10'h0F0, 10, 0, 1, 8'h00);
        // SS_n rising together with bit 0 aborts the frame.
        send_frame(10'h0C3, 9, 0, 1, 8'h00);

        // Reset during the 4th MISO bit of a read-data transfer.
        send_frame(10'h2A5, 10, 0, 1, 8'h00);
        f = 10'h300;
        SS_n = 1'b0;
        tick();
        for (int n = 0; n < 10; n++) begin
            MOSI = f[9-n];
            tick();
            if (n == 9) exp_rx_q.push_back(f);
        end
        flag_m = 1'b0;
        tick();
        rd_byte  = 8'h5A;
        tx_data  = rd_byte;
        tx_valid = 1'b1;
        tick();
        for (int b = 7; b >= 0; b--) exp_miso_q.push_back(rd_byte[b]);
        tx_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        exp_miso_q.delete();
        last_rx = 10'h000;
        SS_n = 1'b1;
        #1;
        chk("reset_mid_miso", 32'(MISO), 32'(0));
        chk("reset_mid_flag", 32'(dut.rd_addr_flag_reg), 32'(0));
        $display("reset applied during read-data shift");
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        // With the flag cleared, a read frame is an address again: no MISO data.
        send_frame(10'h3C3, 10, 2, 1, 8'hA5);

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            int ab;
            ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 9)) : 10;
            send_frame(10'($urandom), ab, int'($urandom_range(0, 4)),
                       int'($urandom_range(1, 3)), 8'($urandom));
        end

        repeat (4) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
